io_sw_debouncer: RTL and testbench

Receive-side conditioning block for the switch input bus that the bench driver produces and the single-cycle core's memory-mapped I/O reads. It synchronizes the raw 32-bit switch word into the core clock domain, debounces it at word level with a prescaled sample tick, and presents a stable registered value to the load path. An optional sticky change flag and per-bit change mask let software poll for switch activity.

---
 rtl/io_sw_debouncer_if.sv | 19 +
 rtl/io_sw_debouncer.sv | 122 ++++++++++++
 tb/tb_io_sw_debouncer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/io_sw_debouncer_if.sv
// Switch-word bus between the raw switch driver (master) and the debouncer (slave).
interface io_sw_debouncer_if;
    logic [31:0] i_io_sw;
    logic        i_rd_en;
    logic [31:0] o_sw_data;
    logic        o_sw_update;
    logic        o_change;
    logic [31:0] o_change_mask;

    modport master (
        output i_io_sw, i_rd_en,
        input  o_sw_data, o_sw_update, o_change, o_change_mask
    );

    modport slave (
        input  i_io_sw, i_rd_en,
        output o_sw_data, o_sw_update, o_change, o_change_mask
    );
endinterface

// File: rtl/io_sw_debouncer.sv
// Synchronizes and word-level debounces the 32-bit switch input for the MMIO load path.
// Optional sticky change flag / mask compiled in with IO_SW_CHANGE_FLAG_EN.

module io_sw_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) ff <= '0;
        else         ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];
endmodule

module io_sw_debouncer #(
    parameter int TICK_DIV    = 1000,
    parameter int STABLE_CNT  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic           i_clk,
    input  logic           i_reset,
    io_sw_debouncer_if.slave sw
);
    localparam int W  = 32;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_CNT);

    logic [W-1:0]  sync_w;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [W-1:0]  cand, cand_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          load, commit;
    logic [W-1:0]  data_q;
    logic          update_q;

    for (genvar b = 0; b < W; b++) begin : g_sync
        io_sw_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
            .i_clk  (i_clk),
            .i_reset(i_reset),
            .d      (sw.i_io_sw[b]),
            .q      (sync_w[b])
        );
    end

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)   tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + TW'(1);
    end

    // A commit is the tick on which cnt reaches CNT_MAX, including a fresh load when CNT_MAX is 1.
    always_comb begin
        load     = tick && (sync_w != cand);
        cand_nxt = cand;
        cnt_nxt  = cnt;
        if (load) begin
            cand_nxt = sync_w;
            cnt_nxt  = CW'(1);
        end else if (tick && (cnt < CNT_MAX)) begin
            cnt_nxt = cnt + CW'(1);
        end
        commit = tick && (cnt_nxt == CNT_MAX) && (load || (cnt != CNT_MAX))
                 && (cand_nxt != data_q);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cand     <= '0;
            cnt      <= '0;
            data_q   <= '0;
            update_q <= 1'b0;
        end else begin
            cand     <= cand_nxt;
            cnt      <= cnt_nxt;
            update_q <= commit;
            if (commit) data_q <= cand_nxt;
        end
    end

    assign sw.o_sw_data   = data_q;
    assign sw.o_sw_update = update_q;

`ifdef IO_SW_CHANGE_FLAG_EN
    logic [W-1:0] diff;
    logic         change_q;
    logic [W-1:0] mask_q;

    assign diff = cand_nxt ^ data_q;

    // A commit colliding with a read restarts the mask from this commit alone.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            change_q <= 1'b0;
            mask_q   <= '0;
        end else if (commit) begin
            change_q <= 1'b1;
            mask_q   <= sw.i_rd_en ? diff : (mask_q | diff);
        end else if (sw.i_rd_en) begin
            change_q <= 1'b0;
            mask_q   <= '0;
        end
    end

    assign sw.o_change      = change_q;
    assign sw.o_change_mask = mask_q;
`else
    assign sw.o_change      = 1'b0;
    assign sw.o_change_mask = '0;
`endif
endmodule

// File: tb/tb_io_sw_debouncer.sv
// Directed bench for io_sw_debouncer (TICK_DIV=4, STABLE_CNT=3, SYNC_STAGES=2).
module tb_io_sw_debouncer;
    localparam int TD = 4;
    localparam int SC = 3;
    localparam int SS = 2;
`ifdef IO_SW_CHANGE_FLAG_EN
    localparam bit FLAG_EN = 1'b1;
`else
    localparam bit FLAG_EN = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_reset;
    io_sw_debouncer_if sw();

    io_sw_debouncer #(.TICK_DIV(TD), .STABLE_CNT(SC), .SYNC_STAGES(SS)) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .sw     (sw)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;
    int unsigned cyc = 0;
    int unsigned rel = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic logic [31:0] fm(input logic [31:0] v);
        return FLAG_EN ? v : 32'h0;
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        int errs = 0;
        int pulses = 0;
        i_reset = 1'b1;
        sw.i_io_sw = 32'h0;
        sw.i_rd_en = 1'b0;
        repeat (10) step();
        checks++;
        if (sw.o_sw_data !== 32'h0 || sw.o_sw_update !== 1'b0 || sw.o_change !== 1'b0
            || sw.o_change_mask !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: data=%h upd=%b chg=%b mask=%h want all 0",
                     sw.o_sw_data, sw.o_sw_update, sw.o_change, sw.o_change_mask);
        end
        i_reset = 1'b0;
        rel = cyc;
        for (int k = 0; k < 100; k++) begin
            step();
            if (sw.o_sw_update) pulses++;
            if (sw.o_sw_data !== 32'h0 || sw.o_change !== 1'b0 || sw.o_change_mask !== 32'h0) errs++;
        end
        checks++;
        if (errs != 0) begin
            failures++;
            $display("FAIL reset_idle: %0d nonzero cycles, want 0", errs);
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL reset_idle_pulse: %0d pulses, want 0", pulses);
        end
    endtask

    task automatic test_clean_change();
        int first = -1;
        int pulses = 0;
        logic upd_first = 1'b0;
        sw.i_io_sw = 32'h0000_00A5;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (sw.o_sw_update) pulses++;
            if (first < 0 && sw.o_sw_data === 32'h0000_00A5) begin
                first = k;
                upd_first = sw.o_sw_update;
            end
        end
        checks++;
        if (first < 11 || first > 14) begin
            failures++;
            $display("FAIL clean_latency: got %0d cycles, want 11..14", first);
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL clean_pulses: got %0d, want 1", pulses);
        end
        checks++;
        if (upd_first !== 1'b1) begin
            failures++;
            $display("FAIL clean_pulse_align: got %b, want 1", upd_first);
        end
        checks++;
        if (sw.o_change !== FLAG_EN) begin
            failures++;
            $display("FAIL clean_change: got %b, want %b", sw.o_change, FLAG_EN);
        end
        checks++;
        if (sw.o_change_mask !== fm(32'h0000_00A5)) begin
            failures++;
            $display("FAIL clean_mask: got %h, want %h", sw.o_change_mask, fm(32'h0000_00A5));
        end
    endtask

    task automatic test_glitch();
        int bad = 0;
        int pulses = 0;
        sw.i_io_sw = 32'h0000_00A4;
        repeat (5) step();
        sw.i_io_sw = 32'h0000_00A5;
        for (int k = 0; k < 30; k++) begin
            step();
            if (sw.o_sw_update) pulses++;
            if (sw.o_sw_data !== 32'h0000_00A5) bad++;
        end
        checks++;
        if (bad != 0 || pulses != 0) begin
            failures++;
            $display("FAIL glitch_reject: bad=%0d pulses=%0d, want 0 and 0", bad, pulses);
        end
        pulses = 0;
        sw.i_io_sw = 32'h0000_00A4;
        for (int k = 0; k < 20; k++) begin
            step();
            if (sw.o_sw_update) pulses++;
        end
        checks++;
        if (sw.o_sw_data !== 32'h0000_00A4 || pulses != 1) begin
            failures++;
            $display("FAIL glitch_commit: data=%h pulses=%0d, want 000000a4 and 1",
                     sw.o_sw_data, pulses);
        end
        checks++;
        if (sw.o_change_mask !== fm(32'h0000_00A5) || sw.o_change !== FLAG_EN) begin
            failures++;
            $display("FAIL glitch_mask_accum: mask=%h chg=%b, want %h %b",
                     sw.o_change_mask, sw.o_change, fm(32'h0000_00A5), FLAG_EN);
        end
    endtask

    task automatic test_read_clear();
        sw.i_rd_en = 1'b1;
        step();
        sw.i_rd_en = 1'b0;
        checks++;
        if (sw.o_change !== 1'b0 || sw.o_change_mask !== 32'h0) begin
            failures++;
            $display("FAIL read_clear: chg=%b mask=%h, want 0 00000000", sw.o_change, sw.o_change_mask);
        end
        sw.i_io_sw = 32'h0000_00A5;
        repeat (20) step();
        checks++;
        if (sw.o_sw_data !== 32'h0000_00A5 || sw.o_change_mask !== fm(32'h0000_0001)) begin
            failures++;
            $display("FAIL pre_collision: data=%h mask=%h, want 000000a5 %h",
                     sw.o_sw_data, sw.o_change_mask, fm(32'h0000_0001));
        end
    endtask

    task automatic test_collision();
        // Align to a tick boundary so the commit edge is exactly 12 edges out.
        for (int k = 0; k < 8 && ((cyc - rel) % TD) != 0; k++) step();
        sw.i_io_sw = 32'h0000_00FF;
        repeat (11) step();
        checks++;
        if (sw.o_sw_data !== 32'h0000_00A5) begin
            failures++;
            $display("FAIL collision_early: data=%h, want 000000a5", sw.o_sw_data);
        end
        sw.i_rd_en = 1'b1;
        step();
        sw.i_rd_en = 1'b0;
        checks++;
        if (sw.o_sw_data !== 32'h0000_00FF || sw.o_sw_update !== 1'b1) begin
            failures++;
            $display("FAIL collision_commit: data=%h upd=%b, want 000000ff 1", sw.o_sw_data, sw.o_sw_update);
        end
        checks++;
        if (sw.o_change !== FLAG_EN || sw.o_change_mask !== fm(32'h0000_005A)) begin
            failures++;
            $display("FAIL collision_status: chg=%b mask=%h, want %b %h",
                     sw.o_change, sw.o_change_mask, FLAG_EN, fm(32'h0000_005A));
        end
        step();
        checks++;
        if (sw.o_sw_update !== 1'b0 || sw.o_change !== FLAG_EN) begin
            failures++;
            $display("FAIL collision_after: upd=%b chg=%b, want 0 %b", sw.o_sw_update, sw.o_change, FLAG_EN);
        end
    endtask

    task automatic test_reset_mid();
        int early = 0;
        sw.i_io_sw = 32'h1234_5678;
        repeat (6) step();
        i_reset = 1'b1;
        #1;
        checks++;
        if (sw.o_sw_data !== 32'h0 || sw.o_sw_update !== 1'b0 || sw.o_change !== 1'b0
            || sw.o_change_mask !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_clear: data=%h upd=%b chg=%b mask=%h want all 0",
                     sw.o_sw_data, sw.o_sw_update, sw.o_change, sw.o_change_mask);
        end
        repeat (3) step();
        i_reset = 1'b0;
        rel = cyc;
        for (int k = 1; k <= 11; k++) begin
            step();
            if (sw.o_sw_data !== 32'h0 || sw.o_sw_update !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL reset_mid_early: %0d early cycles, want 0", early);
        end
        step();
        checks++;
        if (sw.o_sw_data !== 32'h1234_5678 || sw.o_sw_update !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_commit: data=%h upd=%b, want 12345678 1", sw.o_sw_data, sw.o_sw_update);
        end
        checks++;
        if (sw.o_change !== FLAG_EN || sw.o_change_mask !== fm(32'h1234_5678)) begin
            failures++;
            $display("FAIL reset_mid_status: chg=%b mask=%h, want %b %h",
                     sw.o_change, sw.o_change_mask, FLAG_EN, fm(32'h1234_5678));
        end
    endtask

    initial begin
        i_reset = 1'b1;
        sw.i_io_sw = 32'h0;
        sw.i_rd_en = 1'b0;
        test_reset();
        test_clean_change();
        test_glitch();
        test_read_clear();
        test_collision();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time exceeded, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
